// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of
// fifo_stream_reader. The master modport is the reader's view; the slave
// modport is the view of the surrounding FIFO and consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    // FIFO read side
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_underflow_i;
    logic                  fifo_rd_en_o;

    // Downstream stream side
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    // Sticky error flag
    logic                  err_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  fifo_underflow_i,
        output fifo_rd_en_o,
        output m_valid_o,
        output m_data_o,
        input  m_ready_i,
        output err_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output fifo_underflow_i,
        input  fifo_rd_en_o,
        input  m_valid_o,
        input  m_data_o,
        output m_ready_i,
        input  err_o
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for a synchronous FIFO with a 1-cycle
// registered read latency. Issues reads while there is room, captures the
// returned words into a 2-entry buffer (head + skid) and re-presents them as
// a valid/ready stream at up to one word per clock.
//
// Optional feature: define FIFO_RD_ERR_EN to build the sticky error flag
// (FIFO underflow input, or a capture that would overflow the buffer).
// Without it err_o is tied low and no error logic exists.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_stream_reader_if.master bus
);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ_reg;
    occ_t                  occ_next;
    logic                  inflight_reg;
    logic                  valid_reg;
    logic                  valid_next;
    logic [DATA_WIDTH-1:0] head_reg;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic [DATA_WIDTH-1:0] skid_next;

    logic                  pop;
    logic                  rd_en;
    logic                  overflow;
    logic [1:0]            occ_cnt;
    logic [1:0]            occ_after_pop;
    logic [1:0]            level_after;

    // Next-state, read request and buffer steering.
    always_comb begin
        occ_next      = occ_reg;
        head_next     = head_reg;
        skid_next     = skid_reg;
        overflow      = 1'b0;

        occ_cnt       = occ_reg;
        pop           = valid_reg && bus.m_ready_i;
        occ_after_pop = occ_cnt - {1'b0, pop};
        // Words held or on their way after this edge; max 3 only in the
        // unreachable occ==2 + inflight + no-pop case.
        level_after   = occ_after_pop + {1'b0, inflight_reg};

        // Gated by reset so the request drops the moment reset rises.
        rd_en = !rst_i && !bus.fifo_empty_i && (level_after < 2'd2);

        // Popping a full buffer promotes the skid entry to the head.
        if (pop && (occ_reg == TWO)) begin
            head_next = skid_reg;
        end

        // The word requested last cycle is on fifo_data_i now.
        if (inflight_reg) begin
            if (occ_after_pop == 2'd0) begin
                head_next = bus.fifo_data_i;
            end else if (occ_after_pop == 2'd1) begin
                skid_next = bus.fifo_data_i;
            end else begin
                // No room: the word is dropped and flagged.
                overflow = 1'b1;
            end
        end

        case (level_after)
            2'd0:    occ_next = EMPTY;
            2'd1:    occ_next = ONE;
            default: occ_next = TWO;
        endcase

        valid_next = (occ_next != EMPTY);
    end

    // State and data registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_reg      <= EMPTY;
            inflight_reg <= 1'b0;
            valid_reg    <= 1'b0;
            head_reg     <= '0;
            skid_reg     <= '0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= rd_en;
            valid_reg    <= valid_next;
            head_reg     <= head_next;
            skid_reg     <= skid_next;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = valid_reg;
    assign bus.m_data_o     = head_reg;

`ifdef FIFO_RD_ERR_EN
    logic err_reg;
    logic err_next;

    // Error flag accumulates until reset.
    always_comb begin
        err_next = err_reg | bus.fifo_underflow_i | overflow;
    end

    // Sticky error register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.err_o = err_reg;
`else
    logic unused_err_sources;
    assign unused_err_sources = bus.fifo_underflow_i ^ overflow;
    assign bus.err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small behavioural FIFO with a
// registered read port feeds the reader; accepted beats are logged and
// compared against hand-computed sequences.
module tb_fifo_stream_reader;

    localparam int DW = 16;
`ifdef FIFO_RD_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- behavioural FIFO ----------------
    logic [DW-1:0] mem [0:15];
    logic [3:0]    wr_ptr;
    logic [3:0]    rd_ptr;
    int            count;
    logic [DW-1:0] fifo_dout;
    logic          fifo_uf;
    logic          wr_en      = 1'b0;
    logic [DW-1:0] wr_data    = '0;
    logic          hold_empty = 1'b0;
    logic          fake_full  = 1'b0;
    logic          force_uf   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 0;
            fifo_dout <= '0;
            fifo_uf   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (bus.fifo_rd_en_o && count != 0) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 4'd1;
            end
            count   <= count + (wr_en ? 1 : 0) - ((bus.fifo_rd_en_o && count != 0) ? 1 : 0);
            fifo_uf <= bus.fifo_rd_en_o && (count == 0);
        end
    end

    assign bus.fifo_empty_i     = ((count == 0) || hold_empty) && !fake_full;
    assign bus.fifo_data_i      = fifo_dout;
    assign bus.fifo_underflow_i = fifo_uf | force_uf;

    // ---------------- monitor ----------------
    int            cyc = 0;
    logic [DW-1:0] beats [$];
    int            beat_cyc [$];
    int            rd_count    = 0;
    int            first_rd    = -1;
    int            viol        = 0;
    int            uf_seen     = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.m_valid_o && bus.m_ready_i) begin
                beats.push_back(bus.m_data_o);
                beat_cyc.push_back(cyc);
                $display("beat  cyc=%0d data=0x%04h", cyc, bus.m_data_o);
            end
            if (bus.fifo_rd_en_o) begin
                rd_count = rd_count + 1;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.fifo_rd_en_o && bus.fifo_empty_i) viol = viol + 1;
            if (fifo_uf) uf_seen = uf_seen + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        beats.delete();
        beat_cyc.delete();
        first_rd = -1;
        rd_count = 0;
    endtask

    task automatic clear_log();
        beats.delete();
        beat_cyc.delete();
        first_rd = -1;
        rd_count = 0;
    endtask

    int bad;

    initial begin
        bus.m_ready_i = 1'b0;

        // ---- reset with a non-empty FIFO flag ----
        fake_full = 1'b1;
        tick();
        #1;
        check("rst_rd_en", bus.fifo_rd_en_o, 0);
        check("rst_valid", bus.m_valid_o, 0);
        check("rst_data", bus.m_data_o, 0);
        check("rst_err", bus.err_o, 0);
        fake_full = 1'b0;
        do_reset();

        // ---- streaming 8 preloaded words ----
        bus.m_ready_i = 1'b1;
        hold_empty    = 1'b1;
        for (int i = 0; i < 8; i++) push(DW'(i + 1));
        clear_log();
        hold_empty = 1'b0;
        #1;
        check("stream_rd_now", bus.fifo_rd_en_o, 1);
        for (int i = 0; i < 14; i++) tick();
        check("stream_beats", beats.size(), 8);
        check("stream_reads", rd_count, 8);
        check("stream_first_lat", (beat_cyc.size() > 0) ? beat_cyc[0] - first_rd : -1, 2);
        for (int i = 0; i < 8; i++)
            check($sformatf("stream_data%0d", i), (i < beats.size()) ? beats[i] : 16'hDEAD, DW'(i + 1));
        bad = 0;
        for (int i = 1; i < beat_cyc.size(); i++)
            if (beat_cyc[i] != beat_cyc[0] + i) bad++;
        check("stream_back2back", bad, 0);
        check("stream_empty", bus.fifo_empty_i, 1);
        check("stream_rd_idle", bus.fifo_rd_en_o, 0);

        // ---- backpressure ----
        do_reset();
        bus.m_ready_i = 1'b0;
        hold_empty    = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(i + 1));
        clear_log();
        hold_empty = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), bus.m_valid_o, 1);
            check($sformatf("bp_hold%0d", i), bus.m_data_o, 16'h0001);
            tick();
        end
        check("bp_reads", rd_count, 2);
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_beats", beats.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_data%0d", i), (i < beats.size()) ? beats[i] : 16'hDEAD, DW'(i + 1));

        // ---- empty boundary with random ready ----
        do_reset();
        viol    = 0;
        uf_seen = 0;
        for (int i = 0; i < 16; i++) begin
            bus.m_ready_i = 1'($urandom_range(0, 1));
            push(DW'(16'h0100 + i));
            bus.m_ready_i = 1'($urandom_range(0, 1));
            tick();
            bus.m_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("edge_rd_while_empty", viol, 0);
        check("edge_underflow", uf_seen, 0);
        check("edge_beats", beats.size(), 16);
        bad = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] != DW'(16'h0100 + i)) bad++;
        check("edge_order", bad, 0);

        // ---- mid-stream reset with a full buffer ----
        do_reset();
        bus.m_ready_i = 1'b0;
        hold_empty    = 1'b1;
        for (int i = 0; i < 3; i++) push(DW'(16'h0050 + i));
        hold_empty = 1'b0;
        tick();
        tick();
        tick();
        check("mid_pre_valid", bus.m_valid_o, 1);
        rst = 1'b1;
        #1;
        check("mid_valid_drop", bus.m_valid_o, 0);
        check("mid_rd_drop", bus.fifo_rd_en_o, 0);
        tick();
        rst = 1'b0;
        clear_log();
        bus.m_ready_i = 1'b1;
        push(16'h00AA);
        for (int i = 0; i < 6; i++) tick();
        check("mid_beats", beats.size(), 1);
        check("mid_first", (beats.size() > 0) ? beats[0] : 16'hDEAD, 16'h00AA);

        // ---- error flag ----
        force_uf = 1'b1;
        tick();
        force_uf = 1'b0;
        check("err_set", bus.err_o, ERR_EXP);
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", bus.err_o, ERR_EXP);
        do_reset();
        check("err_cleared", bus.err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
